// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronizes and deglitches the keyboard lines, decodes
// 11-bit frames into scancodes and queues them in a first-word-fall-through FIFO.
module ps2_keyboard_rx #(
   parameter int FIFO_DEPTH     = 4,
   parameter int FILTER_LEN     = 4,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       CLK_CPU,
   input  logic       reset,
   input  logic       keyboard_clock,
   input  logic       keyboard_data,
   output logic [7:0] scancode_data,
   output logic       scancode_valid,
   input  logic       scancode_ready,
   output logic       frame_error,
   output logic       overflow,
   input  logic       overflow_clear
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   logic          kclk_meta, kclk_sync, kdat_meta, kdat_sync;
   logic          kclk_filt;
   logic [FW-1:0] filt_cnt;
   logic          fall;

   state_t        state;
   logic [2:0]    bit_cnt;
   logic [7:0]    shift_reg;
   logic          parity_reg;
   logic [TW-1:0] to_cnt;
   logic          stop_ok, push, timeout;

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW:0]   wr_ptr, rd_ptr, fill;
   logic          empty, full, pop, wr_en;

   // Lines idle high, so every conditioning flop resets to 1.
   always_ff @(posedge CLK_CPU or negedge reset) begin
      if (!reset) begin
         kclk_meta <= 1'b1;
         kclk_sync <= 1'b1;
         kdat_meta <= 1'b1;
         kdat_sync <= 1'b1;
         kclk_filt <= 1'b1;
         filt_cnt  <= '0;
      end else begin
         kclk_meta <= keyboard_clock;
         kclk_sync <= kclk_meta;
         kdat_meta <= keyboard_data;
         kdat_sync <= kdat_meta;
         if (kclk_sync == kclk_filt) begin
            filt_cnt <= '0;
         end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
            kclk_filt <= kclk_sync;
            filt_cnt  <= '0;
         end else begin
            filt_cnt <= filt_cnt + 1'b1;
         end
      end
   end

   // Edge is the cycle in which the filtered clock is about to drop.
   assign fall    = kclk_filt && !kclk_sync && (filt_cnt == FW'(FILTER_LEN - 1));
   assign stop_ok = kdat_sync && (^{shift_reg, parity_reg});
   assign push    = (state == STOP) && fall && stop_ok;
   assign timeout = (state != IDLE) && !fall && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge CLK_CPU or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         bit_cnt     <= '0;
         shift_reg   <= '0;
         parity_reg  <= 1'b0;
         to_cnt      <= '0;
         frame_error <= 1'b0;
      end else begin
         frame_error <= 1'b0;
         if (state == IDLE) begin
            to_cnt <= '0;
            if (fall && !kdat_sync) begin
               state   <= DATA;
               bit_cnt <= '0;
            end
         end else if (fall) begin
            to_cnt <= '0;
            case (state)
               DATA: begin
                  shift_reg <= {kdat_sync, shift_reg[7:1]};
                  bit_cnt   <= bit_cnt + 1'b1;
                  if (bit_cnt == 3'd7) state <= PARITY;
               end
               PARITY: begin
                  parity_reg <= kdat_sync;
                  state      <= STOP;
               end
               default: begin
                  state <= IDLE;
                  if (!stop_ok) frame_error <= 1'b1;
               end
            endcase
         end else if (timeout) begin
            state       <= IDLE;
            frame_error <= 1'b1;
            to_cnt      <= '0;
         end else begin
            to_cnt <= to_cnt + 1'b1;
         end
      end
   end

   assign fill  = wr_ptr - rd_ptr;
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (fill == (AW+1)'(FIFO_DEPTH));
   assign pop   = !empty && scancode_ready;
   // A full FIFO still accepts a byte when the head leaves in the same cycle.
   assign wr_en = push && (!full || pop);

   always_ff @(posedge CLK_CPU) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= shift_reg;
   end

   always_ff @(posedge CLK_CPU or negedge reset) begin
      if (!reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         overflow <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (pop)   rd_ptr <= rd_ptr + 1'b1;
         if (push && full && !pop) overflow <= 1'b1;
         else if (overflow_clear)  overflow <= 1'b0;
      end
   end

   assign scancode_valid = !empty;
   assign scancode_data  = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench for ps2_keyboard_rx: good/bad frames, timeout, overflow, glitch, mid-frame reset.
module tb_ps2_keyboard_rx;

   localparam int TO = 5000;

   logic       clk = 1'b0;
   logic       reset, kc, kd, ready, ovc;
   logic [7:0] data;
   logic       valid, ferr, ovf;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int err_cnt  = 0;
   int last_err_cyc = 0;
   int last_fall    = 0;
   int e0;
   logic [7:0] rx_q[$];
   int         pop_q[$];
   logic [10:0] fr;

   ps2_keyboard_rx #(.FIFO_DEPTH(4), .FILTER_LEN(4), .TIMEOUT_CYCLES(TO)) dut (
      .CLK_CPU(clk), .reset(reset), .keyboard_clock(kc), .keyboard_data(kd),
      .scancode_data(data), .scancode_valid(valid), .scancode_ready(ready),
      .frame_error(ferr), .overflow(ovf), .overflow_clear(ovc)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (valid && ready) begin
         rx_q.push_back(data);
         pop_q.push_back(cyc);
         $display("pop  cyc=%0d data=%02h", cyc, data);
      end
      if (ferr) begin
         err_cnt++;
         last_err_cyc = cyc;
         $display("frame_error cyc=%0d", cyc);
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [10:0] good(input logic [7:0] b);
      return {1'b1, ~(^b), b, 1'b0};
   endfunction

   function automatic int rx_at(input int k);
      return (k < rx_q.size()) ? int'(rx_q[k]) : -1;
   endfunction

   function automatic int pop_at(input int k);
      return (k < pop_q.size()) ? pop_q[k] : -1;
   endfunction

   task automatic send_bits(input logic [10:0] f, input int first, input int last, input int half);
      for (int i = first; i <= last; i++) begin
         kd = f[i];
         wait_cyc(half);
         kc = 1'b0;
         last_fall = cyc;
         wait_cyc(half);
         kc = 1'b1;
      end
   endtask

   initial begin
      reset = 1'b0; kc = 1'b1; kd = 1'b1; ready = 1'b0; ovc = 1'b0;
      wait_cyc(4);
      check_eq("rst_valid", 32'(valid), 32'd0);
      check_eq("rst_data", 32'(data), 32'h00);
      check_eq("rst_ferr", 32'(ferr), 32'd0);
      check_eq("rst_ovf", 32'(ovf), 32'd0);
      reset = 1'b1;
      wait_cyc(4);

      // 1: slow good frame; edge is 5 cycles after the line drop, pop 1 cycle later
      ready = 1'b1; rx_q.delete(); pop_q.delete(); e0 = err_cnt;
      send_bits(good(8'h1C), 0, 10, 1000);
      check_eq("t1_count", 32'(rx_q.size()), 32'd1);
      check_eq("t1_data", 32'(rx_at(0)), 32'h1C);
      check_eq("t1_latency", 32'(pop_at(0) - last_fall), 32'd6);
      check_eq("t1_noerr", 32'(err_cnt - e0), 32'd0);
      check_eq("t1_valid_low", 32'(valid), 32'd0);

      // 2: bad parity then a good 0xF0
      rx_q.delete(); e0 = err_cnt;
      fr = {1'b1, 1'b1, 8'h1C, 1'b0};
      send_bits(fr, 0, 10, 20);
      check_eq("t2_err", 32'(err_cnt - e0), 32'd1);
      check_eq("t2_err_time", 32'(last_err_cyc - last_fall), 32'd6);
      check_eq("t2_nopush", 32'(rx_q.size()), 32'd0);
      send_bits(good(8'hF0), 0, 10, 20);
      check_eq("t2_f0", 32'(rx_at(0)), 32'hF0);
      check_eq("t2_err_after", 32'(err_cnt - e0), 32'd1);

      // 3: stop bit low
      rx_q.delete(); e0 = err_cnt;
      fr = {1'b0, 1'b1, 8'h5A, 1'b0};
      send_bits(fr, 0, 10, 20);
      kd = 1'b1;
      wait_cyc(20);
      check_eq("t3_err", 32'(err_cnt - e0), 32'd1);
      check_eq("t3_nopush", 32'(rx_q.size()), 32'd0);

      // 4: truncated frame times out, then 0xAA
      rx_q.delete(); e0 = err_cnt;
      send_bits(good(8'hAA), 0, 3, 20);
      wait_cyc(TO + 50);
      check_eq("t4_err", 32'(err_cnt - e0), 32'd1);
      check_eq("t4_err_time", 32'(last_err_cyc - last_fall), 32'(TO + 6));
      send_bits(good(8'hAA), 0, 10, 20);
      check_eq("t4_aa", 32'(rx_at(0)), 32'hAA);
      check_eq("t4_err_after", 32'(err_cnt - e0), 32'd1);

      // 5: overflow with ready low
      ready = 1'b0; rx_q.delete(); pop_q.delete();
      for (int b = 1; b <= 5; b++) send_bits(good(8'(b)), 0, 10, 20);
      wait_cyc(10);
      check_eq("t5_ovf_set", 32'(ovf), 32'd1);
      check_eq("t5_valid", 32'(valid), 32'd1);
      check_eq("t5_head", 32'(data), 32'h01);
      ready = 1'b1;
      wait_cyc(8);
      for (int k = 0; k < 4; k++) begin
         check_eq($sformatf("t5_pop%0d", k), 32'(rx_at(k)), 32'(k + 1));
         check_eq($sformatf("t5_pop%0d_cyc", k), 32'(pop_at(k) - pop_at(0)), 32'(k));
      end
      check_eq("t5_pops", 32'(rx_q.size()), 32'd4);
      check_eq("t5_empty", 32'(valid), 32'd0);
      check_eq("t5_ovf_sticky", 32'(ovf), 32'd1);
      ovc = 1'b1;
      wait_cyc(1);
      ovc = 1'b0;
      check_eq("t5_ovf_clear", 32'(ovf), 32'd0);

      // 6a: 2-cycle clock glitch with data low must not look like a start bit
      rx_q.delete(); e0 = err_cnt;
      kd = 1'b0;
      wait_cyc(2);
      kc = 1'b0;
      wait_cyc(2);
      kc = 1'b1;
      kd = 1'b1;
      wait_cyc(20);
      send_bits(good(8'h1C), 0, 10, 20);
      check_eq("t6_glitch_data", 32'(rx_at(0)), 32'h1C);
      check_eq("t6_glitch_count", 32'(rx_q.size()), 32'd1);
      check_eq("t6_glitch_noerr", 32'(err_cnt - e0), 32'd0);

      // 6b: reset after 5 bits; d4=1 is ignored, d5=0 restarts, frame then times out
      ready = 1'b0;
      send_bits(good(8'h1C), 0, 10, 20);
      check_eq("t6_held", 32'(valid), 32'd1);
      send_bits(good(8'h1C), 0, 4, 20);
      reset = 1'b0;
      #1;
      check_eq("t6_rst_valid", 32'(valid), 32'd0);
      check_eq("t6_rst_data", 32'(data), 32'h00);
      check_eq("t6_rst_ferr", 32'(ferr), 32'd0);
      wait_cyc(3);
      reset = 1'b1;
      e0 = err_cnt;
      send_bits(good(8'h1C), 5, 10, 20);
      check_eq("t6_nopush", 32'(valid), 32'd0);
      wait_cyc(TO + 50);
      check_eq("t6_nopush_late", 32'(valid), 32'd0);
      check_eq("t6_timeout_err", 32'(err_cnt - e0), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
